// File: rtl/spi_config_loader.sv
// spi_config_loader: mode-0 SPI initiator that shifts a DW-bit configuration
// vector MSB first into a responder shift register while capturing the
// responder's previous contents from MISO.
// Optional feature macro: SPI_CFG_AUTOLOAD_EN (send AUTO_VEC once after reset).
module spi_config_loader #(
  parameter int              DW       = 42,
  parameter int              CLK_DIV  = 2,
  parameter logic [DW-1:0]   AUTO_VEC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rd_data,
  output logic          spi_clk,
  output logic          spi_csn,
  output logic          spi_mosi,
  input  logic          spi_miso
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DW + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_GAP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] div_cnt, div_cnt_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [DW-1:0] tx_sh, tx_sh_n;
  logic [DW-1:0] rx_sh, rx_sh_n;
  logic [DW-1:0] rd_data_n;
  logic          mosi_n;
  logic          done_n;
  logic          phase_end;
  logic          launch;
  logic [DW-1:0] launch_vec;

  assign phase_end = (div_cnt == DIV_LAST);

`ifdef SPI_CFG_AUTOLOAD_EN
  logic auto_pend;

  // One-shot autoload request armed by reset, consumed by the first IDLE cycle
  always_ff @(posedge clk) begin
    if (rst)
      auto_pend <= 1'b1;
    else if (state == S_IDLE)
      auto_pend <= 1'b0;
  end

  assign launch     = auto_pend | start;
  assign launch_vec = auto_pend ? AUTO_VEC : wr_data;
`else
  logic unused_auto;

  assign unused_auto = ^AUTO_VEC;
  assign launch      = start;
  assign launch_vec  = wr_data;
`endif

  // Next-state, shifter and next-output logic; every pin is registered below
  always_comb begin
    state_n   = state;
    div_cnt_n = div_cnt + 1'b1;
    bit_cnt_n = bit_cnt;
    tx_sh_n   = tx_sh;
    rx_sh_n   = rx_sh;
    rd_data_n = rd_data;
    mosi_n    = spi_mosi;
    done_n    = 1'b0;
    case (state)
      S_IDLE: begin
        div_cnt_n = '0;
        if (launch) begin
          state_n   = S_SETUP;
          tx_sh_n   = launch_vec;
          bit_cnt_n = '0;
          mosi_n    = launch_vec[DW-1];
        end
      end
      S_SETUP: begin
        if (phase_end) begin
          state_n   = S_HIGH;
          div_cnt_n = '0;
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          // Falling edge: capture MISO, present the next MOSI bit
          state_n   = S_LOW;
          div_cnt_n = '0;
          rx_sh_n   = {rx_sh[DW-2:0], spi_miso};
          tx_sh_n   = {tx_sh[DW-2:0], 1'b0};
          mosi_n    = tx_sh[DW-2];
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      S_LOW: begin
        if (phase_end) begin
          div_cnt_n = '0;
          if (bit_cnt == BIT_LAST) begin
            state_n = S_GAP;
            mosi_n  = 1'b0;
          end else begin
            state_n = S_HIGH;
          end
        end
      end
      S_GAP: begin
        mosi_n = 1'b0;
        if (phase_end) begin
          state_n   = S_IDLE;
          div_cnt_n = '0;
          rd_data_n = rx_sh;
          done_n    = 1'b1;
        end
      end
      default: begin
        state_n   = S_IDLE;
        div_cnt_n = '0;
      end
    endcase
  end

  // State, counters, shifters and registered pin drivers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rd_data  <= '0;
      spi_clk  <= 1'b0;
      spi_csn  <= 1'b1;
      spi_mosi <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      div_cnt  <= div_cnt_n;
      bit_cnt  <= bit_cnt_n;
      tx_sh    <= tx_sh_n;
      rx_sh    <= rx_sh_n;
      rd_data  <= rd_data_n;
      spi_clk  <= (state_n == S_HIGH);
      spi_csn  <= !(state_n inside {S_SETUP, S_HIGH, S_LOW});
      spi_mosi <= mosi_n;
      busy     <= (state_n != S_IDLE);
      done     <= done_n;
    end
  end

endmodule

// File: doc/spi_config_loader.md
# spi_config_loader

SPI initiator that writes a configuration vector, MSB first, into the FM transmitter's SPI configuration shift register. It also captures the vector previously held in that register from MISO during the same transfer. It sits in the system clock domain, between a host-side control source (a microcontroller bridge or a boot sequencer) and the `spi_clk`/`spi_csn`/`spi_mosi`/`spi_miso` pins of the configuration responder.

## Interface
Parameters:
- `DW`, 42 — configuration vector width. Must equal the responder's shift-register width: 18 + 12 + 5 + 3 + 3 flags + 1 override.
- `CLK_DIV`, 2 — duration of each SPI clock half-period, in `clk` cycles. Minimum 1.
- `AUTO_VEC`, {DW{1'b0}} — vector sent automatically after reset. Used only when autoload is compiled in.

Ports:
- `clk` input 1 — system clock.
- `rst` input 1 — reset. Synchronous, active-high.
- `start` input 1 — request a transfer. Sampled only in IDLE.
- `wr_data` input DW — vector to send. Latched in the cycle `start` is accepted.
- `busy` output 1 — high while a transfer is in progress.
- `done` output 1 — one-cycle pulse when a transfer completes.
- `rd_data` output DW — vector captured from MISO during the last completed transfer.
- `spi_clk` output 1 — SPI clock. Mode 0; idles low.
- `spi_csn` output 1 — chip select, active low.
- `spi_mosi` output 1 — serial data to the responder.
- `spi_miso` input 1 — serial data from the responder. Treated as synchronous to `clk`; the responder changes MISO only on `spi_clk` rising edges, which this block generates.

## Operation
- Reset values: `spi_csn`=1, `spi_clk`=0, `spi_mosi`=0, `busy`=0, `done`=0, `rd_data`=0. All internal counters are cleared.
- States: IDLE → SETUP → HIGH ↔ LOW → GAP → IDLE.
- IDLE. `start`=1 latches `wr_data` into the TX shifter and moves to SETUP. `start` in any other state is ignored.
- SETUP. Lasts `CLK_DIV` cycles.
  - `spi_csn`=0, `spi_clk`=0.
  - `spi_mosi` = TX bit DW-1.
- HIGH. Lasts `CLK_DIV` cycles with `spi_clk`=1. The responder samples MOSI on entry.
- LOW. Lasts `CLK_DIV` cycles with `spi_clk`=0.
  - On entry, shift `spi_miso` into the LSB of the RX shifter.
  - On entry, drive the next TX bit onto `spi_mosi`.
  - When the bit counter reaches DW, the final LOW phase goes to GAP instead of HIGH. It also serves as the CSn hold time.
- GAP. Lasts `CLK_DIV` cycles.
  - `spi_csn`=1, `spi_mosi`=0.
  - In its last cycle, copy the RX shifter to `rd_data`.
  - Return to IDLE with `done`=1 for one cycle.
- MISO alignment: the k-th MISO sample (k = 1..DW) is bit DW-k of the responder's prior contents. `rd_data` therefore equals the responder vector before this write, MSB at DW-1.
- Exactly DW rising edges of `spi_clk` occur per transfer. There are no edges while `spi_csn`=1.
- `rst` in any state returns all outputs to their reset values in the next cycle. A transfer is never resumed after reset. The responder may hold a partially shifted vector and must be rewritten.

## Timing
- `start` accepted at edge 0:
  - Edge 1: `busy`=1, `spi_csn`=0, MOSI = bit DW-1.
- Each bit lasts 2·`CLK_DIV` cycles.
- `busy` stays high for exactly 2·`CLK_DIV`·(DW+1) cycles. This is 172 cycles at the defaults.
- `done`=1 and `busy`=0 in the same cycle, immediately after the last GAP cycle. `rd_data` is valid from that cycle on.
- A new `start` in the `done` cycle is accepted. CSn-high time between transfers is therefore at least `CLK_DIV`+1 cycles.
- All SPI outputs come directly from flip-flops, with no combinational paths to pins.

## Configuration
- Macro `SPI_CFG_AUTOLOAD_EN`.
- Defined:
  - After `rst` deasserts, the block starts one transfer of `AUTO_VEC` in the first cycle, without `start`.
  - `busy` is high from the cycle after reset release.
  - While the autoload transfer runs, `start` is ignored.
- Undefined: the block stays in IDLE until `start`, and `AUTO_VEC` is unused.

## Test plan
- Defaults, with a responder model whose shift register was reset. `start` with `wr_data`=42'h2AA_5555_5555:
  - 42 rising edges on `spi_clk`.
  - Responder register equals 42'h2AA_5555_5555.
  - `done` occurs 172 cycles after `busy` rises.
- Two back-to-back transfers, A=42'h3FF_0000_FFFF then B=42'h000_FFFF_0000, with `start` asserted in the `done` cycle:
  - Second `rd_data` = 42'h3FF_0000_FFFF.
  - `spi_csn` high for ≥3 cycles between the transfers.
- `start` held high throughout the transfer → exactly one transfer; `done` pulses once.
- `rst` asserted at bit 20 → next cycle `spi_csn`=1, `spi_clk`=0, `busy`=0, `rd_data`=0. No further `spi_clk` edges.
- `CLK_DIV`=1, DW=42 → `spi_clk` toggles every cycle; `busy` lasts 86 cycles; the responder write is correct.
- With `SPI_CFG_AUTOLOAD_EN` and `AUTO_VEC`=42'h155_AAAA_AAAA → release `rst` with no `start`; `done` after 172 cycles; the responder holds `AUTO_VEC`.
